// File: rtl/fre_pkg.sv
// Shared constants for the frequency-counter gate sequencer: state codes,
// range codes and the range-to-gate-length mapping.
package fre_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_GATE   = 3'd2;
    localparam logic [2:0] ST_LATCH  = 3'd3;
    localparam logic [2:0] ST_ADJUST = 3'd4;

    localparam logic [1:0] RNG_1S    = 2'd0;
    localparam logic [1:0] RNG_100MS = 2'd1;
    localparam logic [1:0] RNG_10MS  = 2'd2;

    function automatic int unsigned gate_cycles(input logic [1:0] rng,
                                                input int unsigned clk_freq);
        case (rng)
            RNG_1S:    return clk_freq;
            RNG_100MS: return clk_freq / 10;
            default:   return clk_freq / 100;
        endcase
    endfunction

    // Code 3 has no gate length of its own; it behaves as the shortest range.
    function automatic logic [1:0] clamp_range(input logic [1:0] rng);
        return (rng == 2'd3) ? RNG_10MS : rng;
    endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, i.e. in the
// last cycle of a loaded interval.
module gate_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         Rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!Rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign tc = (count == '0);

endmodule

// File: rtl/fre_gate_ctrl.sv
// Gate/clear/latch sequencer for the cascaded BCD frequency counter, with
// auto-ranging across 1 s, 100 ms and 10 ms gates.
module fre_gate_ctrl
    import fre_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned CLR_CYC    = 2,
    parameter bit          AUTO_RANGE = 1'b1
) (
    input  logic       clk,
    input  logic       Rst_n,
    input  logic       run,
    input  logic [1:0] range_init,
    input  logic       ovf_in,
    input  logic       msd_zero,
    output logic       cnt_clr_n,
    output logic       gate,
    output logic       latch,
    output logic [1:0] range,
    output logic       ovf_flag,
    output logic       busy
);

    localparam int TW = ($clog2(CLK_FREQ) > 4) ? $clog2(CLK_FREQ) : 4;

    logic [2:0]    state, state_nxt;
    logic [1:0]    range_nxt;
    logic          sticky, sticky_nxt;
    logic          msd_q;
    logic          remeasure;
    logic          latch_nxt;
    logic          tmr_load, tmr_tc;
    logic [TW-1:0] tmr_val;

    gate_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .Rst_n    (Rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_nxt = state;
        range_nxt = range;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        remeasure = AUTO_RANGE && sticky && (range < RNG_10MS);
        case (state)
            ST_IDLE:   if (run) state_nxt = ST_CLEAR;
            ST_CLEAR:  if (tmr_tc) state_nxt = ST_GATE;
            ST_GATE:   if (tmr_tc) state_nxt = ST_LATCH;
            ST_LATCH:  state_nxt = ST_ADJUST;
            ST_ADJUST: begin
                if (remeasure) begin
                    range_nxt = range + 2'd1;
                    state_nxt = ST_CLEAR;
                end else begin
                    if (AUTO_RANGE && !sticky && msd_q && (range != RNG_1S))
                        range_nxt = range - 2'd1;
                    state_nxt = run ? ST_CLEAR : ST_IDLE;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase

        // The timer is reloaded on entry to each timed phase.
        if (state_nxt == ST_CLEAR && state != ST_CLEAR) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(CLR_CYC - 1);
        end else if (state_nxt == ST_GATE && state != ST_GATE) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(gate_cycles(range, CLK_FREQ) - 1);
        end
    end

    // sticky_nxt already includes ovf_in of the final gate cycle.
    assign sticky_nxt = (state == ST_CLEAR) ? 1'b0 : (sticky | (gate & ovf_in));
    assign latch_nxt  = (state_nxt == ST_LATCH) &&
                        (!sticky_nxt || (range == RNG_10MS) || !AUTO_RANGE);

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            range     <= clamp_range(range_init);
            sticky    <= 1'b0;
            msd_q     <= 1'b0;
            cnt_clr_n <= 1'b1;
            gate      <= 1'b0;
            latch     <= 1'b0;
            ovf_flag  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            range     <= range_nxt;
            sticky    <= sticky_nxt;
            if (state == ST_LATCH)
                msd_q <= msd_zero;
            cnt_clr_n <= (state_nxt != ST_CLEAR);
            gate      <= (state_nxt == ST_GATE);
            latch     <= latch_nxt;
            if (latch_nxt)
                ovf_flag <= sticky_nxt & ((range == RNG_10MS) || !AUTO_RANGE);
            busy      <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_fre_gate_ctrl.sv
// Scoreboard bench for fre_gate_ctrl: dut0 auto-ranges, dut1 has a fixed range.
module tb_fre_gate_ctrl;

    localparam int unsigned CF = 1000;

    typedef struct {
        int clr_len;
        int gate_len;
        int latched;
        int ovf;
        int rng;
        int period;
    } rec_t;

    logic       clk = 1'b0;
    logic [1:0] rstn_v, run_v, ovf_v, msd_v;
    logic [1:0] rinit [2];
    logic [1:0] clr_v, gate_v, latch_v, oflag_v, busy_v;
    logic [1:0] rng_o [2];

    rec_t exp_q0 [$];
    rec_t exp_q1 [$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    fre_gate_ctrl #(.CLK_FREQ(CF), .CLR_CYC(2), .AUTO_RANGE(1'b1)) dut0 (
        .clk(clk), .Rst_n(rstn_v[0]), .run(run_v[0]), .range_init(rinit[0]),
        .ovf_in(ovf_v[0]), .msd_zero(msd_v[0]), .cnt_clr_n(clr_v[0]),
        .gate(gate_v[0]), .latch(latch_v[0]), .range(rng_o[0]),
        .ovf_flag(oflag_v[0]), .busy(busy_v[0])
    );

    fre_gate_ctrl #(.CLK_FREQ(CF), .CLR_CYC(2), .AUTO_RANGE(1'b0)) dut1 (
        .clk(clk), .Rst_n(rstn_v[1]), .run(run_v[1]), .range_init(rinit[1]),
        .ovf_in(ovf_v[1]), .msd_zero(msd_v[1]), .cnt_clr_n(clr_v[1]),
        .gate(gate_v[1]), .latch(latch_v[1]), .range(rng_o[1]),
        .ovf_flag(oflag_v[1]), .busy(busy_v[1])
    );

    function automatic void checkOutput(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endfunction

    function automatic rec_t mk(input int c, input int g, input int l,
                                input int o, input int r, input int p);
        rec_t e;
        e.clr_len = c; e.gate_len = g; e.latched = l;
        e.ovf = o; e.rng = r; e.period = p;
        return e;
    endfunction

    function automatic void push_exp(input int g, input rec_t e);
        if (g == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int g, input logic r, input logic o, input logic m);
        run_v[g] = r;
        ovf_v[g] = o;
        msd_v[g] = m;
    endtask

    task automatic wait_gate(input int g, input logic lvl);
        int n = 0;
        while (gate_v[g] !== lvl && n < 3000) begin
            tick();
            n++;
        end
        if (gate_v[g] !== lvl) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL dut%0d gate wait: gate stayed %0d, expected %0d", g, gate_v[g], lvl);
        end
    endtask

    task automatic wait_gate_rise(input int g);
        wait_gate(g, 1'b0);
        wait_gate(g, 1'b1);
    endtask

    // Pulse ovf_in for one cycle in gate cycle k (1-based) of the next window.
    task automatic inject(input int g, input int k);
        wait_gate_rise(g);
        repeat (k - 1) tick();
        ovf_v[g] = 1'b1;
        tick();
        ovf_v[g] = 1'b0;
    endtask

    task automatic wait_drain(input int g, input int budget);
        int n = 0;
        while (((g == 0) ? exp_q0.size() : exp_q1.size()) > 0 && n < budget) begin
            tick();
            n++;
        end
        if (((g == 0) ? exp_q0.size() : exp_q1.size()) > 0) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL dut%0d drain: %0d windows outstanding, expected 0", g,
                     (g == 0) ? exp_q0.size() : exp_q1.size());
            if (g == 0) exp_q0.delete();
            else        exp_q1.delete();
        end
    endtask

    // Each falling edge of gate marks the LATCH cycle of a measurement window.
    task automatic monitor(input int g);
        int   clr_cnt = 0;
        int   gate_cnt = 0;
        int   cyc = 0;
        int   last_fall = 0;
        bit   prev_gate = 1'b0;
        int   qs;
        rec_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn_v[g]) begin
                clr_cnt   = 0;
                gate_cnt  = 0;
                prev_gate = 1'b0;
            end else begin
                if (!clr_v[g]) clr_cnt++;
                if (gate_v[g]) gate_cnt++;
                if (prev_gate && !gate_v[g]) begin
                    qs = (g == 0) ? exp_q0.size() : exp_q1.size();
                    if (qs == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("[TB] FAIL dut%0d window: unexpected %0d-cycle gate, expected none", g, gate_cnt);
                    end else begin
                        if (g == 0) e = exp_q0.pop_front();
                        else        e = exp_q1.pop_front();
                        checkOutput($sformatf("dut%0d clear length", g), clr_cnt, e.clr_len);
                        checkOutput($sformatf("dut%0d gate length", g), gate_cnt, e.gate_len);
                        checkOutput($sformatf("dut%0d latch", g), int'(latch_v[g]), e.latched);
                        checkOutput($sformatf("dut%0d ovf_flag", g), int'(oflag_v[g]), e.ovf);
                        checkOutput($sformatf("dut%0d range", g), int'(rng_o[g]), e.rng);
                        if (e.period > 0)
                            checkOutput($sformatf("dut%0d period", g), cyc - last_fall, e.period);
                    end
                    last_fall = cyc;
                    clr_cnt   = 0;
                    gate_cnt  = 0;
                end else if (latch_v[g]) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL dut%0d stray latch: got 1, expected 0", g);
                end
                prev_gate = gate_v[g];
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        rstn_v   = 2'b00;
        rinit[0] = 2'd0;
        rinit[1] = 2'd1;
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("dut%0d reset cnt_clr_n", g), int'(clr_v[g]), 1);
            checkOutput($sformatf("dut%0d reset gate", g), int'(gate_v[g]), 0);
            checkOutput($sformatf("dut%0d reset latch", g), int'(latch_v[g]), 0);
            checkOutput($sformatf("dut%0d reset ovf_flag", g), int'(oflag_v[g]), 0);
            checkOutput($sformatf("dut%0d reset busy", g), int'(busy_v[g]), 0);
        end
        checkOutput("dut0 reset range", int'(rng_o[0]), 0);
        checkOutput("dut1 reset range", int'(rng_o[1]), 1);

        // Normal continuous run at 1 s: two windows, period 1004.
        push_exp(0, mk(2, 1000, 1, 0, 0, 0));
        push_exp(0, mk(2, 1000, 1, 0, 0, 1004));
        rstn_v = 2'b11;
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        repeat (10) tick();
        checkOutput("dut0 busy while measuring", int'(busy_v[0]), 1);
        wait_drain(0, 2500);

        // Overflow at 1 s: no latch, re-measure at 100 ms.
        push_exp(0, mk(2, 1000, 0, 0, 0, 0));
        push_exp(0, mk(2, 100, 1, 0, 1, 0));
        inject(0, 500);
        wait_drain(0, 1500);

        // Overflow at 100 ms, then at 10 ms (flagged), then a clean 10 ms window.
        push_exp(0, mk(2, 100, 0, 0, 1, 0));
        push_exp(0, mk(2, 10, 1, 1, 2, 0));
        push_exp(0, mk(2, 10, 1, 0, 2, 0));
        inject(0, 50);
        inject(0, 3);
        wait_gate(0, 1'b0);
        ovf_v[0] = 1'b1;
        wait_gate(0, 1'b1);
        ovf_v[0] = 1'b0;
        wait_drain(0, 500);

        // msd_zero walks the range back down to 1 s and holds it there.
        wait_gate_rise(0);
        push_exp(0, mk(2, 10, 1, 0, 2, 0));
        push_exp(0, mk(2, 100, 1, 0, 1, 0));
        push_exp(0, mk(2, 1000, 1, 0, 0, 0));
        msd_v[0] = 1'b1;
        wait_drain(0, 2000);

        // run dropped mid-gate: window completes and latches, then IDLE.
        push_exp(0, mk(2, 1000, 1, 0, 0, 0));
        wait_gate_rise(0);
        repeat (100) tick();
        run_v[0] = 1'b0;
        wait_drain(0, 1500);
        repeat (4) tick();
        checkOutput("dut0 stop busy", int'(busy_v[0]), 0);
        checkOutput("dut0 stop range", int'(rng_o[0]), 0);
        checkOutput("dut0 stop gate", int'(gate_v[0]), 0);
        checkOutput("dut0 stop cnt_clr_n", int'(clr_v[0]), 1);

        // One-cycle reset mid-gate aborts without a latch; range_init 3 maps to 2.
        rinit[0] = 2'd3;
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        wait_gate_rise(0);
        repeat (50) tick();
        rstn_v[0] = 1'b0;
        run_v[0]  = 1'b0;
        tick();
        rstn_v[0] = 1'b1;
        checkOutput("dut0 abort gate", int'(gate_v[0]), 0);
        checkOutput("dut0 abort latch", int'(latch_v[0]), 0);
        checkOutput("dut0 abort range", int'(rng_o[0]), 2);
        checkOutput("dut0 abort busy", int'(busy_v[0]), 0);
        repeat (20) tick();
        checkOutput("dut0 idle after abort", int'(busy_v[0]), 0);

        // Fixed range: overflow at 100 ms is latched and flagged, range stays 1.
        push_exp(1, mk(2, 100, 1, 1, 1, 0));
        run_v[1] = 1'b1;
        inject(1, 10);
        run_v[1] = 1'b0;
        wait_drain(1, 500);
        repeat (4) tick();
        checkOutput("dut1 fixed range", int'(rng_o[1]), 1);
        checkOutput("dut1 idle busy", int'(busy_v[1]), 0);
        checkOutput("dut1 ovf_flag held", int'(oflag_v[1]), 1);

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
